// File: rtl/response_checker_if.sv
// ---------------------------------------------------------------------------
// response_checker_if
// Streaming response/expected-vector channel into the response checker.
//   in_valid  : producer has a resp/expected pair on the bus
//   in_ready  : checker accepts the pair this cycle
//   resp      : circuit primary-output vector (WIDTH bits)
//   expected  : golden (good-machine) vector (WIDTH bits)
//   care_mask : present only when RESP_CHECK_MASK_EN is defined;
//               a 0 bit marks a don't-care output
// Modports: master = vector source, slave = checker.
// ---------------------------------------------------------------------------
interface response_checker_if #(
    parameter int WIDTH = 108
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] resp;
    logic [WIDTH-1:0] expected;
`ifdef RESP_CHECK_MASK_EN
    logic [WIDTH-1:0] care_mask;

    modport master (output in_valid, resp, expected, care_mask, input in_ready);
    modport slave  (input in_valid, resp, expected, care_mask, output in_ready);
`else
    modport master (output in_valid, resp, expected, input in_ready);
    modport slave  (input in_valid, resp, expected, output in_ready);
`endif
endinterface

// File: rtl/response_checker.sv
// ---------------------------------------------------------------------------
// response_checker
// Consumes a benchmark circuit's output vectors over a bounded session of N
// vectors: counts mismatching vectors, records the first failing index and
// compacts every response into a 32-bit MISR signature.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : one-cycle pulse, starts a session when not busy
//   num_vectors       : session length, sampled on an accepted start
//   stream (slave)    : in_valid/in_ready/resp/expected[/care_mask]
//   busy, done        : session running / session complete (held)
//   mismatch_count    : failing vectors, saturating
//   first_fail_valid  : any failure seen this session
//   first_fail_idx    : 0-based index of the first failing vector
//   signature         : MISR value
// Optional feature macro: RESP_CHECK_MASK_EN (adds stream.care_mask; masked
// bits are neither compared nor compacted).
// ---------------------------------------------------------------------------
module response_checker #(
    parameter int          WIDTH = 108,
    parameter int          IDX_W = 14,
    parameter logic [31:0] POLY  = 32'h04C11DB7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [IDX_W-1:0]   num_vectors,
    response_checker_if.slave  stream,
    output logic               busy,
    output logic               done,
    output logic [IDX_W-1:0]   mismatch_count,
    output logic               first_fail_valid,
    output logic [IDX_W-1:0]   first_fail_idx,
    output logic [31:0]        signature
);
    localparam int NCHUNK = (WIDTH + 31) / 32;
    localparam int PAD_W  = NCHUNK * 32;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] n_reg, n_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [IDX_W-1:0] cnt_reg, cnt_next;
    logic             ffv_reg, ffv_next;
    logic [IDX_W-1:0] ffi_reg, ffi_next;
    logic [31:0]      sig_reg, sig_next;

    logic [WIDTH-1:0] care;
    logic [PAD_W-1:0] resp_pad;
    logic [31:0]      chunk [NCHUNK];
    logic [31:0]      fold;
    logic             diff_any;
    logic             transfer;

`ifdef RESP_CHECK_MASK_EN
    assign care = stream.care_mask;
`else
    assign care = '1;
`endif

    // Zero-pad the (masked) response to a whole number of 32-bit chunks.
    assign resp_pad = PAD_W'(stream.resp & care);

    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
            assign chunk[gi] = resp_pad[gi*32 +: 32];
        end
    endgenerate

    always_comb begin
        fold = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            fold = fold ^ chunk[i];
        end
    end

    assign diff_any        = |((stream.resp ^ stream.expected) & care);
    assign stream.in_ready = (state_reg == RUN);
    assign transfer        = stream.in_valid && (state_reg == RUN);

    always_comb begin
        state_next = state_reg;
        n_next     = n_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg;
        ffv_next   = ffv_reg;
        ffi_next   = ffi_reg;
        sig_next   = sig_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    n_next     = num_vectors;
                    idx_next   = '0;
                    cnt_next   = '0;
                    ffv_next   = 1'b0;
                    ffi_next   = '0;
                    sig_next   = '0;
                    state_next = (num_vectors != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (transfer) begin
                    idx_next = idx_reg + 1'b1;
                    if (diff_any) begin
                        if (cnt_reg != '1) begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                        if (!ffv_reg) begin
                            ffv_next = 1'b1;
                            ffi_next = idx_reg;
                        end
                    end
                    sig_next = {sig_reg[30:0], 1'b0} ^ (sig_reg[31] ? POLY : 32'h0) ^ fold;
                    if (idx_reg == n_reg - 1'b1) begin
                        state_next = DONE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            n_reg     <= '0;
            idx_reg   <= '0;
            cnt_reg   <= '0;
            ffv_reg   <= 1'b0;
            ffi_reg   <= '0;
            sig_reg   <= '0;
        end else begin
            state_reg <= state_next;
            n_reg     <= n_next;
            idx_reg   <= idx_next;
            cnt_reg   <= cnt_next;
            ffv_reg   <= ffv_next;
            ffi_reg   <= ffi_next;
            sig_reg   <= sig_next;
        end
    end

    assign busy             = (state_reg == RUN);
    assign done             = (state_reg == DONE);
    assign mismatch_count   = cnt_reg;
    assign first_fail_valid = ffv_reg;
    assign first_fail_idx   = ffi_reg;
    assign signature        = sig_reg;
endmodule

// File: tb/tb_response_checker.sv
// ---------------------------------------------------------------------------
// tb_response_checker
// Directed bench for response_checker. Inputs change on the falling edge and
// outputs are sampled on the falling edge, away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_response_checker;
    localparam int WIDTH = 108;
    localparam int IDX_W = 14;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [IDX_W-1:0] num_vectors;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] mismatch_count;
    logic             first_fail_valid;
    logic [IDX_W-1:0] first_fail_idx;
    logic [31:0]      signature;

    int tests_run    = 0;
    int tests_failed = 0;

    response_checker_if #(.WIDTH(WIDTH)) stream_if ();

    response_checker #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .num_vectors      (num_vectors),
        .stream           (stream_if),
        .busy             (busy),
        .done             (done),
        .mismatch_count   (mismatch_count),
        .first_fail_valid (first_fail_valid),
        .first_fail_idx   (first_fail_idx),
        .signature        (signature)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic [IDX_W-1:0] n);
        start       = 1'b1;
        num_vectors = n;
        tick();
        start       = 1'b0;
    endtask

    task automatic send(input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] e);
        stream_if.in_valid = 1'b1;
        stream_if.resp     = r;
        stream_if.expected = e;
        tick();
        stream_if.in_valid = 1'b0;
    endtask

    logic [WIDTH-1:0] top_bit;
    logic             vpat [6];
    logic [WIDTH-1:0] vval [6];

    initial begin
        top_bit            = '0;
        top_bit[WIDTH-1]   = 1'b1;
        vpat               = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vval               = '{108'd3, 108'd0, 108'd0, 108'd5, 108'd0, 108'd7};

        rst                = 1'b1;
        start              = 1'b0;
        num_vectors        = '0;
        stream_if.in_valid = 1'b0;
        stream_if.resp     = '0;
        stream_if.expected = '0;
`ifdef RESP_CHECK_MASK_EN
        stream_if.care_mask = '1;
`endif
        tick();
        tick();
        check_value("reset_in_ready", stream_if.in_ready, 0);
        check_value("reset_busy", busy, 0);
        check_value("reset_done", done, 0);
        check_value("reset_count", mismatch_count, 0);
        check_value("reset_sig", signature, 0);
        rst = 1'b0;
        tick();

        // Three all-zero matching vectors.
        pulse_start(3);
        check_value("t1_in_ready_run", stream_if.in_ready, 1);
        check_value("t1_busy_run", busy, 1);
        send('0, '0);
        send('0, '0);
        check_value("t1_not_done_early", done, 0);
        send('0, '0);
        check_value("t1_done", done, 1);
        check_value("t1_busy_done", busy, 0);
        check_value("t1_count", mismatch_count, 0);
        check_value("t1_ffv", first_fail_valid, 0);
        check_value("t1_sig", signature, 0);

        // MISR: 0x1 then shift with zero fold -> 0x2.
        pulse_start(2);
        send(108'd1, 108'd1);
        send(108'd0, 108'd0);
        check_value("t2_done", done, 1);
        check_value("t2_sig", signature, 32'h0000_0002);

        // Vectors 1 and 3 fail in bit 107 (bit 11 of chunk 3).
        // sig: 0 -> 0x800 -> 0x1000 -> 0x2000^0x800 = 0x2800
        pulse_start(4);
        send('0, '0);
        send(top_bit, '0);
        send('0, '0);
        send(top_bit, '0);
        check_value("t3_done", done, 1);
        check_value("t3_count", mismatch_count, 2);
        check_value("t3_ffv", first_fail_valid, 1);
        check_value("t3_ffi", first_fail_idx, 1);
        check_value("t3_sig", signature, 32'h0000_2800);

        // Zero-length session from a DONE state with non-zero results.
        pulse_start(0);
        check_value("t4_done", done, 1);
        check_value("t4_busy", busy, 0);
        check_value("t4_in_ready", stream_if.in_ready, 0);
        check_value("t4_count", mismatch_count, 0);
        check_value("t4_ffv", first_fail_valid, 0);
        check_value("t4_ffi", first_fail_idx, 0);
        check_value("t4_sig", signature, 0);

        // Gappy valid, start pulsed mid-run (N=1) must be ignored.
        // sig: 3 -> 6^5=3 -> 6^7=1
        pulse_start(3);
        check_value("t5_done_cleared", done, 0);
        for (int i = 0; i < 6; i++) begin
            stream_if.in_valid = vpat[i];
            stream_if.resp     = vval[i];
            stream_if.expected = vval[i];
            start              = (i == 1);
            num_vectors        = 1;
            tick();
            start              = 1'b0;
            stream_if.in_valid = 1'b0;
            if (i == 4) begin
                check_value("t5_busy_mid", busy, 1);
                check_value("t5_done_mid", done, 0);
            end
        end
        check_value("t5_done", done, 1);
        check_value("t5_in_ready_done", stream_if.in_ready, 0);
        check_value("t5_sig", signature, 32'h0000_0001);
        check_value("t5_count", mismatch_count, 0);
        tick();
        check_value("t5_done_held", done, 1);

        // Reset mid-session after two failing transfers; the reset-cycle
        // transfer is discarded.
        pulse_start(5);
        send(108'd1, '0);
        send(108'd2, '0);
        check_value("t6_count_pre", mismatch_count, 2);
        rst                = 1'b1;
        stream_if.in_valid = 1'b1;
        stream_if.resp     = 108'd4;
        stream_if.expected = '0;
        tick();
        rst                = 1'b0;
        stream_if.in_valid = 1'b0;
        check_value("t6_busy", busy, 0);
        check_value("t6_done", done, 0);
        check_value("t6_in_ready", stream_if.in_ready, 0);
        check_value("t6_count", mismatch_count, 0);
        check_value("t6_ffv", first_fail_valid, 0);
        check_value("t6_sig", signature, 0);
        tick();
        check_value("t6_idle_in_ready", stream_if.in_ready, 0);

        // Single-vector failing session: first failure at index 0.
        pulse_start(1);
        send(108'd9, 108'd8);
        check_value("t7_done", done, 1);
        check_value("t7_ffv", first_fail_valid, 1);
        check_value("t7_ffi", first_fail_idx, 0);
        check_value("t7_sig", signature, 32'h0000_0009);

`ifdef RESP_CHECK_MASK_EN
        // Difference only in masked bit 5: no mismatch, signature as in t2.
        stream_if.care_mask    = '1;
        stream_if.care_mask[5] = 1'b0;
        pulse_start(2);
        send(108'h21, 108'h01);
        send(108'h00, 108'h00);
        check_value("t8_count", mismatch_count, 0);
        check_value("t8_ffv", first_fail_valid, 0);
        check_value("t8_sig", signature, 32'h0000_0002);
        stream_if.care_mask = '1;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
